// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display scan controller.
package display_pkg;

    localparam int unsigned NUM_DIGITS       = 4;
    localparam int unsigned DEF_REFRESH_DIV  = 100000;
    localparam int unsigned DEF_BLANK_CYCLES = 16;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/display_scan_ctrl_slot_timer.sv
// Digit-slot timer: per-slot cycle counter, digit index and blank/show phase.
// in_blank and idx describe the upcoming cycle so the top can register outputs in step with cnt.
module slot_timer
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       wrap,
    output logic       in_blank,
    output logic [1:0] idx
);

    localparam int unsigned     CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    scan_state_e   state_q, state_d;

    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        state_d = state_q;
        if (wrap) begin
            state_d = S_BLANK;
        end else if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
        end
        in_blank = (state_d == S_BLANK);
        idx      = idx_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit common-anode display scan controller with frame-synchronous double buffering.
// All outputs are registered from the slot timer's next-cycle view, giving zero lag to cnt/idx.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    blank,
    output logic                    frame_start
);

    logic       wrap;
    logic       blank_n;
    logic [1:0] idx_n;
    logic       frame_edge;

    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_en_q, disp_en_d;

    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  blank_q, blank_d;
    logic                  frame_start_q, frame_start_d;

    slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_slot_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrap    (wrap),
        .in_blank(blank_n),
        .idx     (idx_n)
    );

    assign frame_edge = wrap && (idx_n == 2'd0);

    always_comb begin
        pend_val_d = pend_val_q;
        pend_en_d  = pend_en_q;
        pend_vld_d = pend_vld_q;
        disp_val_d = disp_val_q;
        disp_en_d  = disp_en_q;
        // A load coinciding with the frame edge bypasses the pending buffer.
        if (frame_edge) begin
            pend_vld_d = 1'b0;
            if (load) begin
                disp_val_d = value_in;
                disp_en_d  = digit_en_in;
            end else if (pend_vld_q) begin
                disp_val_d = pend_val_q;
                disp_en_d  = pend_en_q;
            end
        end else if (load) begin
            pend_val_d = value_in;
            pend_en_d  = digit_en_in;
            pend_vld_d = 1'b1;
        end

        nibble_d      = nibble_q;
        anode_d       = '1;
        blank_d       = blank_n;
        frame_start_d = frame_edge;
        if (blank_n) begin
            nibble_d = disp_val_d[{idx_n, 2'b00} +: 4];
        end else begin
            anode_d[idx_n] = ~disp_en_d[idx_n];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_val_q    <= '0;
            pend_en_q     <= '0;
            pend_vld_q    <= 1'b0;
            disp_val_q    <= '0;
            disp_en_q     <= '0;
            nibble_q      <= '0;
            anode_q       <= '1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            pend_val_q    <= pend_val_d;
            pend_en_q     <= pend_en_d;
            pend_vld_q    <= pend_vld_d;
            disp_val_q    <= disp_val_d;
            disp_en_q     <= disp_en_d;
            nibble_q      <= nibble_d;
            anode_q       <= anode_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign nibble      = nibble_q;
    assign anode       = anode_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule
